// File: rtl/buzzer_pattern.sv
// Buzzer pattern generator: single/double/triple/continuous beeps, tone or steady drive.
// Ports: clk, reset (sync, active-high), trigger (rising edge), mode[1:0], stop (level),
//        buzzer_out (registered drive), busy (pattern running), done (1-cycle completion pulse).
module buzzer_pattern #(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned TONE_HZ    = 2000,
    parameter int unsigned BEEP_MS    = 200,
    parameter int unsigned GAP_MS     = 100,
    parameter bit          TONE_EN    = 1'b1,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       trigger,
    input  logic [1:0] mode,
    input  logic       stop,
    output logic       buzzer_out,
    output logic       busy,
    output logic       done
);

    localparam logic [31:0] HALF     = 32'(CLK_FREQ / (2 * TONE_HZ));
    localparam logic [31:0] BEEP_CYC = 32'((CLK_FREQ / 1000) * BEEP_MS);
    localparam logic [31:0] GAP_CYC  = 32'((CLK_FREQ / 1000) * GAP_MS);
    localparam logic        OFF_LVL  = ACTIVE_LOW ? 1'b1 : 1'b0;
    localparam logic        ON_LVL   = ~OFF_LVL;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BEEP = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] tone_q, tone_d;
    logic        phase_q, phase_d;
    logic [1:0]  left_q, left_d;
    logic [1:0]  mode_q, mode_d;
    logic        trig_q;
    logic        buz_q, buz_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        rise;

    // Previous sample resets to 1 so a trigger held through reset is not an edge.
    assign rise = trigger & ~trig_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tone_d  = tone_q;
        phase_d = phase_q;
        left_d  = left_q;
        mode_d  = mode_q;
        done_d  = 1'b0;

        if (stop) begin
            state_d = IDLE;
            cnt_d   = '0;
            tone_d  = '0;
            left_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (rise) begin
                        state_d = BEEP;
                        cnt_d   = '0;
                        tone_d  = '0;
                        phase_d = ON_LVL;
                        mode_d  = mode;
                        unique case (mode)
                            2'b00:   left_d = 2'd1;
                            2'b01:   left_d = 2'd2;
                            2'b10:   left_d = 2'd3;
                            default: left_d = 2'd0;
                        endcase
                    end
                end
                BEEP: begin
                    if (cnt_q == BEEP_CYC - 32'd1) begin
                        cnt_d = '0;
                        if (mode_q == 2'b11 || left_q > 2'd1) begin
                            state_d = GAP;
                            if (mode_q != 2'b11)
                                left_d = left_q - 2'd1;
                        end else begin
                            state_d = IDLE;
                            left_d  = '0;
                            done_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                        // Half-period tone counter; phase flips each HALF cycles.
                        if (tone_q == HALF - 32'd1) begin
                            tone_d  = '0;
                            phase_d = ~phase_q;
                        end else begin
                            tone_d = tone_q + 32'd1;
                        end
                    end
                end
                GAP: begin
                    if (cnt_q == GAP_CYC - 32'd1) begin
                        state_d = BEEP;
                        cnt_d   = '0;
                        tone_d  = '0;
                        phase_d = ON_LVL;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
        if (state_d == BEEP)
            buz_d = TONE_EN ? phase_d : ON_LVL;
        else
            buz_d = OFF_LVL;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tone_q  <= '0;
            phase_q <= OFF_LVL;
            left_q  <= '0;
            mode_q  <= '0;
            trig_q  <= 1'b1;
            buz_q   <= OFF_LVL;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tone_q  <= tone_d;
            phase_q <= phase_d;
            left_q  <= left_d;
            mode_q  <= mode_d;
            trig_q  <= trigger;
            buz_q   <= buz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign buzzer_out = buz_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
